csr_scratch_walker: RTL

Hardware CSR scratchpad walker for the host-test environment. It steps through a runtime-programmed table of NUM_TGT CSR targets. Each target is identified by its PF/VF/VA routing and its scratchpad address. For each target it issues write/read-back pairs over a simple request/response CSR port and compares the returned data. It sits between the test controller and the host CSR access path, and reports per-target pass/fail and timeout status.

---
 rtl/csr_scratch_walker.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_scratch_walker.sv
// CSR scratchpad walker: per target, write/read-back of P_i then ~P_i over a req/rsp CSR port.
// Optional pre-read and restore of the original value when CSR_WALK_RESTORE_EN is defined.
module csr_scratch_walker #(
  parameter int          NUM_TGT     = 5,
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 64,
  parameter logic [63:0] PATTERN     = 64'h5A5A_C3C3_0F0F_A5A5,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_TGT*ADDR_W-1:0] tgt_addr,
  input  logic [NUM_TGT*3-1:0]      tgt_pf,
  input  logic [NUM_TGT*11-1:0]     tgt_vf,
  input  logic [NUM_TGT-1:0]        tgt_va,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic                      req_write,
  output logic [ADDR_W-1:0]         req_addr,
  output logic [2:0]                req_pf,
  output logic [10:0]               req_vf,
  output logic                      req_va,
  output logic [DATA_W-1:0]         req_wdata,
  input  logic                      rsp_valid,
  input  logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [NUM_TGT-1:0]        fail_mask,
  output logic [NUM_TGT-1:0]        timeout_mask
);

  localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_TGT - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] BASE     = DATA_W'(PATTERN);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ORIG, S_WAIT_ORIG, S_WR, S_RD, S_WAIT_RSP,
    S_CHECK, S_RESTORE, S_NEXT, S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   nidx;
  logic               pass_sel;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               timed_out;
  logic [DATA_W-1:0]  rsp_q;
  logic               check_end;
  logic [ADDR_W-1:0]  sel_addr, nsel_addr;
  logic [2:0]         sel_pf, nsel_pf;
  logic [10:0]        sel_vf, nsel_vf;
  logic               sel_va, nsel_va;
`ifdef CSR_WALK_RESTORE_EN
  logic [DATA_W-1:0]  orig_q;
  logic               orig_vld;
`endif

  function automatic logic [DATA_W-1:0] pattern_for(input logic [IDX_W-1:0] i, input logic inv);
    logic [DATA_W-1:0] p;
    p = BASE ^ DATA_W'(i);
    return inv ? ~p : p;
  endfunction

  // Table slots for the current target and for the one after it (clamped at the last slot)
  always_comb begin
    nidx      = (idx == LAST_IDX) ? idx : idx + IDX_W'(1);
    sel_addr  = tgt_addr[idx*ADDR_W +: ADDR_W];
    sel_pf    = tgt_pf[idx*3 +: 3];
    sel_vf    = tgt_vf[idx*11 +: 11];
    sel_va    = tgt_va[idx];
    nsel_addr = tgt_addr[nidx*ADDR_W +: ADDR_W];
    nsel_pf   = tgt_pf[nidx*3 +: 3];
    nsel_vf   = tgt_vf[nidx*11 +: 11];
    nsel_va   = tgt_va[nidx];
    check_end = timed_out | pass_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      pass_sel     <= 1'b0;
      tmo_cnt      <= '0;
      timed_out    <= 1'b0;
      req_valid    <= 1'b0;
      req_write    <= 1'b0;
      req_addr     <= '0;
      req_pf       <= '0;
      req_vf       <= '0;
      req_va       <= 1'b0;
      req_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_mask    <= '0;
      timeout_mask <= '0;
`ifdef CSR_WALK_RESTORE_EN
      orig_vld     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_mask    <= '0;
            timeout_mask <= '0;
            idx          <= '0;
            pass_sel     <= 1'b0;
            busy         <= 1'b1;
            req_valid    <= 1'b1;
            req_addr     <= tgt_addr[ADDR_W-1:0];
            req_pf       <= tgt_pf[2:0];
            req_vf       <= tgt_vf[10:0];
            req_va       <= tgt_va[0];
`ifdef CSR_WALK_RESTORE_EN
            req_write    <= 1'b0;
            state        <= S_RD_ORIG;
`else
            req_write    <= 1'b1;
            req_wdata    <= pattern_for('0, 1'b0);
            state        <= S_WR;
`endif
          end
        end
`ifdef CSR_WALK_RESTORE_EN
        S_RD_ORIG: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            tmo_cnt   <= '0;
            state     <= S_WAIT_ORIG;
          end
        end
        S_WAIT_ORIG: begin
          if (rsp_valid || tmo_cnt == TMO_LAST) begin
            if (rsp_valid) begin
              orig_q   <= rsp_data;
              orig_vld <= 1'b1;
            end else begin
              orig_vld          <= 1'b0;
              fail_mask[idx]    <= 1'b1;
              timeout_mask[idx] <= 1'b1;
            end
            req_valid <= 1'b1;
            req_write <= 1'b1;
            req_wdata <= pattern_for(idx, 1'b0);
            req_addr  <= sel_addr;
            req_pf    <= sel_pf;
            req_vf    <= sel_vf;
            req_va    <= sel_va;
            state     <= S_WR;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_RESTORE: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= S_NEXT;
          end
        end
`endif
        S_WR: begin
          if (req_ready) begin
            req_write <= 1'b0;
            req_addr  <= sel_addr;
            req_pf    <= sel_pf;
            req_vf    <= sel_vf;
            req_va    <= sel_va;
            state     <= S_RD;
          end
        end
        S_RD: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            tmo_cnt   <= '0;
            state     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          // A response on the final count still wins over the timeout
          if (rsp_valid) begin
            rsp_q     <= rsp_data;
            timed_out <= 1'b0;
            state     <= S_CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            timed_out <= 1'b1;
            state     <= S_CHECK;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (timed_out) begin
            fail_mask[idx]    <= 1'b1;
            timeout_mask[idx] <= 1'b1;
          end else if (rsp_q != pattern_for(idx, pass_sel)) begin
            fail_mask[idx] <= 1'b1;
          end
          if (!check_end) begin
            pass_sel  <= 1'b1;
            req_valid <= 1'b1;
            req_write <= 1'b1;
            req_wdata <= pattern_for(idx, 1'b1);
            req_addr  <= sel_addr;
            req_pf    <= sel_pf;
            req_vf    <= sel_vf;
            req_va    <= sel_va;
            state     <= S_WR;
          end else begin
`ifdef CSR_WALK_RESTORE_EN
            if (orig_vld) begin
              req_valid <= 1'b1;
              req_write <= 1'b1;
              req_wdata <= orig_q;
              req_addr  <= sel_addr;
              req_pf    <= sel_pf;
              req_vf    <= sel_vf;
              req_va    <= sel_va;
              state     <= S_RESTORE;
            end else begin
              state <= S_NEXT;
            end
`else
            state <= S_NEXT;
`endif
          end
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (fail_mask == '0);
            state <= S_DONE;
          end else begin
            idx       <= nidx;
            pass_sel  <= 1'b0;
            req_valid <= 1'b1;
            req_addr  <= nsel_addr;
            req_pf    <= nsel_pf;
            req_vf    <= nsel_vf;
            req_va    <= nsel_va;
`ifdef CSR_WALK_RESTORE_EN
            req_write <= 1'b0;
            state     <= S_RD_ORIG;
`else
            req_write <= 1'b1;
            req_wdata <= pattern_for(nidx, 1'b0);
            state     <= S_WR;
`endif
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
